write_data: RTL and testbench

Frame sink at the far end of the pixel stream produced by the team's hex-image reader. It captures one full frame of two-pixel-per-clock RGB data framed by `vertical_Pulse` and `horizontal_Pulse`, then serializes it as a 24-bit BMP byte stream. The stream is a 54-byte header followed by bottom-up BGR pixel data, sent over a valid/ready byte interface to a file-dump or UART stage.

---
 rtl/bmp_pkg.sv | 26 ++
 rtl/write_data_if.sv | 9 +
 rtl/bmp_header_rom.sv | 37 +++
 rtl/write_data.sv | 141 ++++++++++++++
 tb/tb_write_data.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bmp_pkg.sv
// rtl/bmp_pkg.sv - shared BMP constants, header field offsets and writer states
package bmp_pkg;

  localparam int HDR_LEN  = 54;
  localparam int DIB_SIZE = 40;
  localparam int BPP      = 24;

  localparam int OFF_MAGIC      = 0;
  localparam int OFF_FILE_SIZE  = 2;
  localparam int OFF_PIX_OFFSET = 10;
  localparam int OFF_DIB_SIZE   = 14;
  localparam int OFF_WIDTH      = 18;
  localparam int OFF_HEIGHT     = 22;
  localparam int OFF_PLANES     = 26;
  localparam int OFF_BPP        = 28;
  localparam int OFF_IMG_SIZE   = 34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HEADER,
    ST_PIXELS,
    ST_DONE
  } state_t;

endpackage

// File: rtl/write_data_if.sv
// rtl/write_data_if.sv - valid/ready byte stream from the BMP writer to its sink
interface write_data_if;
  logic [7:0] byte_Data;
  logic       byte_Valid;
  logic       byte_Ready;

  modport master (output byte_Data, output byte_Valid, input byte_Ready);
  modport slave  (input byte_Data, input byte_Valid, output byte_Ready);
endinterface

// File: rtl/bmp_header_rom.sv
// rtl/bmp_header_rom.sv - combinational 54-byte BMP header lookup for a WxH 24-bit image
module bmp_header_rom
  import bmp_pkg::*;
#(
  parameter int W = 768,
  parameter int H = 512
) (
  input  logic [5:0] i_index,
  output logic [7:0] o_byte
);

  localparam logic [31:0] IMG_SIZE  = 32'(3 * W * H);
  localparam logic [31:0] FILE_SIZE = 32'(HDR_LEN) + IMG_SIZE;

  // Fields are disjoint, so the header byte is the OR of every little-endian field lookup.
  function automatic logic [7:0] field(input int idx, input int off, input int len,
                                       input logic [31:0] v);
    if (idx >= off && idx < off + len) return 8'(v >> (8 * (idx - off)));
    return 8'h00;
  endfunction

  int w_idx;

  always_comb begin
    w_idx  = int'(i_index);
    o_byte = field(w_idx, OFF_MAGIC,      2, 32'h0000_4D42)
           | field(w_idx, OFF_FILE_SIZE,  4, FILE_SIZE)
           | field(w_idx, OFF_PIX_OFFSET, 4, 32'(HDR_LEN))
           | field(w_idx, OFF_DIB_SIZE,   4, 32'(DIB_SIZE))
           | field(w_idx, OFF_WIDTH,      4, 32'(W))
           | field(w_idx, OFF_HEIGHT,     4, 32'(H))
           | field(w_idx, OFF_PLANES,     2, 32'd1)
           | field(w_idx, OFF_BPP,        2, 32'(BPP))
           | field(w_idx, OFF_IMG_SIZE,   4, IMG_SIZE);
  end

endmodule

// File: rtl/write_data.sv
// rtl/write_data.sv - captures one two-pixel-per-clock RGB frame and streams it out as a bottom-up 24-bit BMP
module write_data
  import bmp_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vertical_Pulse,
  input  logic         horizontal_Pulse,
  input  logic [7:0]   data_Red_Even,
  input  logic [7:0]   data_Green_Even,
  input  logic [7:0]   data_Blue_Even,
  input  logic [7:0]   data_Red_Odd,
  input  logic [7:0]   data_Green_Odd,
  input  logic [7:0]   data_Blue_Odd,
  write_data_if.master byte_if,
  output logic         sig_Busy,
  output logic         sig_Write_Done
);

  localparam int NUM_PAIRS = IMAGE_WIDTH * IMAGE_HEIGHT / 2;
  localparam int PAIR_W    = $clog2(NUM_PAIRS);
  localparam int ROW_W     = $clog2(IMAGE_HEIGHT);
  localparam int COL_W     = $clog2(IMAGE_WIDTH);
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);
  localparam logic [ROW_W-1:0]  TOP_ROW   = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMAGE_WIDTH - 1);

  state_t            r_state, w_next;
  logic [47:0]       r_mem [NUM_PAIRS];
  logic [PAIR_W-1:0] r_pair_cnt;
  logic [5:0]        r_hdr_idx;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [1:0]        r_sel;

  logic              w_valid, w_fire, w_pair_write, w_last_pair;
  logic              w_hdr_last, w_row_end, w_pix_last;
  logic [PAIR_W-1:0] w_addr;
  logic [47:0]       w_entry;
  logic [23:0]       w_pixel;
  logic [7:0]        w_hdr_byte, w_pix_byte;

  assign w_valid      = (r_state == ST_HEADER) || (r_state == ST_PIXELS);
  assign w_fire       = w_valid && byte_if.byte_Ready;
  assign w_pair_write = (r_state == ST_CAPTURE) && !vertical_Pulse && horizontal_Pulse;
  assign w_last_pair  = w_pair_write && (r_pair_cnt == LAST_PAIR);
  assign w_hdr_last   = (r_hdr_idx == 6'(HDR_LEN - 1));
  assign w_row_end    = (r_sel == 2'd2) && (r_col == LAST_COL);
  assign w_pix_last   = w_row_end && (r_row == '0);

  bmp_header_rom #(.W(IMAGE_WIDTH), .H(IMAGE_HEIGHT)) u_header_rom (
    .i_index (r_hdr_idx),
    .o_byte  (w_hdr_byte)
  );

  always_ff @(posedge clk) begin
    if (w_pair_write)
      r_mem[r_pair_cnt] <= {data_Red_Even, data_Green_Even, data_Blue_Even,
                            data_Red_Odd,  data_Green_Odd,  data_Blue_Odd};
  end

  // Even pixel lives in the upper half of each entry; byte order out is B, G, R.
  assign w_addr  = PAIR_W'((int'(r_row) * IMAGE_WIDTH + int'(r_col)) >> 1);
  assign w_entry = r_mem[w_addr];
  assign w_pixel = r_col[0] ? w_entry[23:0] : w_entry[47:24];

  always_comb begin
    w_pix_byte = w_pixel[23:16];
    case (r_sel)
      2'd0:    w_pix_byte = w_pixel[7:0];
      2'd1:    w_pix_byte = w_pixel[15:8];
      default: w_pix_byte = w_pixel[23:16];
    endcase
  end

  assign byte_if.byte_Valid = w_valid;
  assign byte_if.byte_Data  = (r_state == ST_HEADER) ? w_hdr_byte :
                              (r_state == ST_PIXELS) ? w_pix_byte : 8'h00;
  assign sig_Busy           = w_valid || (r_state == ST_CAPTURE);
  assign sig_Write_Done     = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (vertical_Pulse)          w_next = ST_CAPTURE;
      ST_CAPTURE: if (w_last_pair)             w_next = ST_HEADER;
      ST_HEADER:  if (w_fire && w_hdr_last)    w_next = ST_PIXELS;
      ST_PIXELS:  if (w_fire && w_pix_last)    w_next = ST_DONE;
      ST_DONE:                                 w_next = ST_IDLE;
      default:                                 w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pair_cnt <= '0;
      r_hdr_idx  <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_sel      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (vertical_Pulse) r_pair_cnt <= '0;
        ST_CAPTURE: begin
          if (vertical_Pulse)    r_pair_cnt <= '0;
          else if (w_pair_write) r_pair_cnt <= w_last_pair ? '0 : r_pair_cnt + 1'b1;
          if (w_last_pair) begin
            r_hdr_idx <= '0;
            r_row     <= TOP_ROW;
            r_col     <= '0;
            r_sel     <= '0;
          end
        end
        ST_HEADER: if (w_fire) r_hdr_idx <= r_hdr_idx + 1'b1;
        ST_PIXELS: if (w_fire) begin
          if (r_sel == 2'd2) begin
            r_sel <= '0;
            if (r_col == LAST_COL) begin
              r_col <= '0;
              if (r_row != '0) r_row <= r_row - 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else begin
            r_sel <= r_sel + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_write_data.sv
// tb/tb_write_data.sv - randomized self-checking bench for write_data against a byte-stream model
module tb_write_data;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int NP     = W * H / 2;
  localparam int NBYTES = 54 + 3 * W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vertical_Pulse = 1'b0;
  logic       horizontal_Pulse = 1'b0;
  logic [7:0] dre = 8'h0, dge = 8'h0, dbe = 8'h0, dro = 8'h0, dgo = 8'h0, dbo = 8'h0;
  logic       sig_Busy, sig_Write_Done;

  write_data_if bus();

  write_data #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk              (clk),
    .reset            (reset),
    .vertical_Pulse   (vertical_Pulse),
    .horizontal_Pulse (horizontal_Pulse),
    .data_Red_Even    (dre),
    .data_Green_Even  (dge),
    .data_Blue_Even   (dbe),
    .data_Red_Odd     (dro),
    .data_Green_Odd   (dgo),
    .data_Blue_Odd    (dbo),
    .byte_if          (bus),
    .sig_Busy         (sig_Busy),
    .sig_Write_Done   (sig_Write_Done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] pix [W*H];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_b [NBYTES];
  int          got_n = 0, done_cnt = 0, cyc = 0, start_cyc = 0, stalls = 0;
  logic        prev_stall = 1'b0, prev_valid = 1'b0, prev_done = 1'b0;
  logic [7:0]  prev_data = 8'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push32(input logic [31:0] v);
    for (int k = 0; k < 4; k++) exp_q.push_back(v[8*k +: 8]);
  endtask

  task automatic push16(input logic [15:0] v);
    exp_q.push_back(v[7:0]);
    exp_q.push_back(v[15:8]);
  endtask

  task automatic build_exp();
    logic [23:0] p;
    exp_q.delete();
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h4D);
    push32(32'(54 + 3 * W * H));
    push32(32'd0);
    push32(32'd54);
    push32(32'd40);
    push32(32'(W));
    push32(32'(H));
    push16(16'd1);
    push16(16'd24);
    push32(32'd0);
    push32(32'(3 * W * H));
    for (int k = 0; k < 4; k++) push32(32'd0);
    for (int r = H - 1; r >= 0; r--)
      for (int c = 0; c < W; c++) begin
        p = pix[r * W + c];
        exp_q.push_back(p[7:0]);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[23:16]);
      end
  endtask

  task automatic randomize_frame();
    for (int k = 0; k < W * H; k++) pix[k] = 24'($urandom);
  endtask

  // Compare step, evaluated at every falling edge.
  task automatic monitor();
    logic v, rdy, d;
    logic [7:0] dat;
    cyc++;
    if (!reset) begin
      got_n = 0; prev_stall = 1'b0; prev_valid = 1'b0; prev_done = 1'b0;
      return;
    end
    v = bus.byte_Valid; rdy = bus.byte_Ready; dat = bus.byte_Data; d = sig_Write_Done;
    if (!v) chk("idle_data_zero", 32'(dat), 32'd0);
    if (v)  chk("busy_while_valid", 32'(sig_Busy), 32'd1);
    if (prev_stall) begin
      chk("stall_valid_held", 32'(v), 32'd1);
      chk("stall_data_stable", 32'(dat), 32'(prev_data));
    end
    if (v && !prev_valid) begin start_cyc = cyc; stalls = 0; end
    if (v && !rdy) stalls++;
    if (v && rdy) begin
      if (got_n < exp_q.size()) chk("stream_byte", 32'(dat), 32'(exp_q[got_n]));
      else                      chk("stream_overrun", 32'(got_n), 32'(exp_q.size()));
      if (got_n < NBYTES) got_b[got_n] = dat;
      got_n++;
    end
    if (d) begin
      done_cnt++;
      chk("done_single_pulse", 32'(prev_done), 32'd0);
      chk("done_byte_count", 32'(got_n), 32'(NBYTES));
      chk("done_latency", 32'(cyc - start_cyc), 32'(NBYTES + stalls));
      chk("done_not_busy", 32'(sig_Busy), 32'd0);
      got_n = 0;
    end
    prev_stall = v && !rdy; prev_data = dat; prev_valid = v; prev_done = d;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input int i);
    horizontal_Pulse = 1'b1;
    {dre, dge, dbe} = pix[2 * i];
    {dro, dgo, dbo} = pix[2 * i + 1];
  endtask

  task automatic drive_junk(input logic h);
    horizontal_Pulse = h;
    {dre, dge, dbe, dro, dgo, dbo} = {16'($urandom), $urandom};
  endtask

  task automatic capture(input int gap, input bit restart);
    bus.byte_Ready = 1'b1;
    vertical_Pulse = 1'b1;
    drive_junk(restart);
    cycle();
    vertical_Pulse = 1'b0;
    if (restart) begin
      for (int k = 0; k < 3; k++) begin drive_junk(1'b1); cycle(); end
      vertical_Pulse = 1'b1;
      drive_junk(1'b1);
      cycle();
      vertical_Pulse = 1'b0;
    end
    for (int i = 0; i < NP; i++) begin
      if (i == gap)
        for (int k = 0; k < 5; k++) begin drive_junk(1'b0); cycle(); end
      drive_pair(i);
      if (i == NP - 1) chk("capture_no_valid_yet", 32'(bus.byte_Valid), 32'd0);
      cycle();
    end
    drive_junk(1'b0);
    chk("header_entry_valid", 32'(bus.byte_Valid), 32'd1);
    chk("header_entry_busy", 32'(sig_Busy), 32'd1);
  endtask

  // mode 0: ready held high; 1: random ready; 2: random ready plus stray input pulses
  task automatic stream(input int mode);
    int d0;
    d0 = done_cnt;
    for (int n = 0; n < 600; n++) begin
      bus.byte_Ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mode == 2) begin
        vertical_Pulse = 1'($urandom_range(0, 1));
        drive_junk(1'($urandom_range(0, 1)));
      end
      cycle();
      if (done_cnt != d0) break;
    end
    vertical_Pulse = 1'b0;
    horizontal_Pulse = 1'b0;
    bus.byte_Ready = 1'b1;
    chk("frame_completed", 32'(done_cnt - d0), 32'd1);
    for (int k = 0; k < 3; k++) cycle();
  endtask

  initial begin
    bus.byte_Ready = 1'b1;
    cycle();
    cycle();
    chk("reset_valid", 32'(bus.byte_Valid), 32'd0);
    chk("reset_data", 32'(bus.byte_Data), 32'd0);
    chk("reset_busy", 32'(sig_Busy), 32'd0);
    chk("reset_done", 32'(sig_Write_Done), 32'd0);
    reset = 1'b1;
    cycle();

    randomize_frame();
    build_exp();
    capture(-1, 1'b0);
    stream(0);
    chk("lit_magic_b", 32'(got_b[0]), 32'h42);
    chk("lit_magic_m", 32'(got_b[1]), 32'h4D);
    chk("lit_fsize0", 32'(got_b[2]), 32'h4E);
    chk("lit_fsize1", 32'(got_b[3]), 32'h00);
    chk("lit_offset", 32'(got_b[10]), 32'h36);
    chk("lit_dib", 32'(got_b[14]), 32'h28);
    chk("lit_width", 32'(got_b[18]), 32'h04);
    chk("lit_height", 32'(got_b[22]), 32'h02);
    chk("lit_planes", 32'(got_b[26]), 32'h01);
    chk("lit_bpp", 32'(got_b[28]), 32'h18);
    chk("lit_imgsize", 32'(got_b[34]), 32'h18);
    chk("lit_first_pix", 32'({got_b[56], got_b[55], got_b[54]}), 32'(pix[W]));
    chk("lit_last_pix", 32'({got_b[77], got_b[76], got_b[75]}), 32'(pix[W - 1]));

    capture(-1, 1'b0);
    stream(2);

    randomize_frame();
    build_exp();
    capture(1, 1'b0);
    stream(1);

    randomize_frame();
    build_exp();
    capture(-1, 1'b1);
    stream(0);

    randomize_frame();
    build_exp();
    capture(-1, 1'b0);
    for (int k = 0; k < 60; k++) cycle();
    chk("abort_in_pixels", 32'(bus.byte_Valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.byte_Valid), 32'd0);
    chk("abort_data", 32'(bus.byte_Data), 32'd0);
    chk("abort_busy", 32'(sig_Busy), 32'd0);
    chk("abort_done", 32'(sig_Write_Done), 32'd0);
    cycle();
    reset = 1'b1;
    cycle();
    randomize_frame();
    build_exp();
    capture(-1, 1'b0);
    stream(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
